// File: rtl/led_breather.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_breather: tick-stepped breathing ramp driving a free-running PWM LED. |
// | Optional LED_BREATHER_GAMMA_EN selects a square-law duty source.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module led_breather #(
  parameter int PWM_BITS   = 8,
  parameter int HOLD_TICKS = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                tick,
  output logic                led,
  output logic [PWM_BITS-1:0] level,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RISE    = 3'd1,
    S_HOLD_HI = 3'd2,
    S_FALL    = 3'd3,
    S_HOLD_LO = 3'd4
  } state_t;

  localparam logic [PWM_BITS-1:0] c_full = '1;
  localparam logic [PWM_BITS-1:0] c_one  = PWM_BITS'(1);
  localparam logic [15:0]         c_hold = 16'(HOLD_TICKS);

  state_t              r_state;
  logic [PWM_BITS-1:0] r_level;
  logic [15:0]         r_hold;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_duty_q;
  logic                r_led;
  logic [15:0]         w_hold_inc;
  logic [PWM_BITS-1:0] w_duty;

  assign w_hold_inc = r_hold + 16'd1;

`ifdef LED_BREATHER_GAMMA_EN
  // Full-width square, keep the upper half: (level*level) >> PWM_BITS.
  logic [2*PWM_BITS-1:0] w_prod;
  assign w_prod = {{PWM_BITS{1'b0}}, r_level} * {{PWM_BITS{1'b0}}, r_level};
  assign w_duty = w_prod[2*PWM_BITS-1:PWM_BITS];
`else
  assign w_duty = r_level;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_level   <= '0;
      r_hold    <= '0;
      r_pwm_cnt <= '0;
      r_duty_q  <= '0;
      r_led     <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + c_one;
      r_led     <= (r_pwm_cnt < r_duty_q);
      // Duty only changes at the period boundary so no PWM period is cut short.
      if (r_pwm_cnt == c_full) begin
        r_duty_q <= w_duty;
      end

      if (!enable) begin
        r_state <= S_IDLE;
        r_level <= '0;
        r_hold  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_RISE;
          end
          S_RISE: begin
            if (tick) begin
              r_level <= r_level + c_one;
              if (r_level == c_full - c_one) begin
                r_state <= S_HOLD_HI;
                r_hold  <= '0;
              end
            end
          end
          S_HOLD_HI, S_HOLD_LO: begin
            if (tick) begin
              if (w_hold_inc == c_hold) begin
                r_state <= (r_state == S_HOLD_HI) ? S_FALL : S_RISE;
                r_hold  <= '0;
              end else begin
                r_hold <= w_hold_inc;
              end
            end
          end
          S_FALL: begin
            if (tick) begin
              r_level <= r_level - c_one;
              if (r_level == c_one) begin
                r_state <= S_HOLD_LO;
                r_hold  <= '0;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_level <= '0;
            r_hold  <= '0;
          end
        endcase
      end
    end
  end

  assign led   = r_led;
  assign level = r_level;
  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_led_breather.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_led_breather: directed bench for led_breather (PWM_BITS=4, HOLD=2).   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_led_breather;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       tick;
  logic       led;
  logic [3:0] level;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_breather #(
    .PWM_BITS   (4),
    .HOLD_TICKS (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (tick),
    .led     (led),
    .level   (level),
    .state   (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_duty(input int lv);
`ifdef LED_BREATHER_GAMMA_EN
    return (lv * lv) >> 4;
`else
    return lv;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic count_led(output int ones);
    ones = 0;
    repeat (16) begin
      step();
      ones += int'(led);
    end
  endtask

  // Advance past the next pwm_cnt wrap, i.e. the cycle duty_q reloads.
  task automatic wait_wrap(input string tag);
    int found;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (dut.r_pwm_cnt == 4'd15) begin
        found = 1;
        break;
      end
      step();
    end
    chk(tag, found, 1);
    step();
  endtask

  initial begin
    int ones;
    int found;
    reset_n = 1'b0;
    enable  = 1'b0;
    tick    = 1'b0;
    step();
    step();
    chk("rst_state", state, 0);
    chk("rst_level", level, 0);
    chk("rst_led", led, 0);
    chk("rst_duty", dut.r_duty_q, 0);
    chk("rst_pwmcnt", dut.r_pwm_cnt, 0);

    // 1: enable without ticks
    reset_n = 1'b1;
    enable  = 1'b1;
    chk("t1_idle_before_edge", state, 0);
    step();
    chk("t1_rise", state, 1);
    for (int i = 0; i < 64; i++) begin
      step();
      chk("t1_level0", level, 0);
      chk("t1_led0", led, 0);
    end

    // 2: fifteen back-to-back ticks, then the high hold
    for (int i = 1; i <= 15; i++) begin
      pulse();
      chk("t2_level", level, i);
    end
    chk("t2_hold_hi", state, 2);
    pulse();
    chk("t2_hold_hi_1", state, 2);
    pulse();
    chk("t2_fall", state, 3);
    chk("t2_fall_level", level, 15);

    // 3: full loop, tick every 20 cycles
    repeat (34) step();
    chk("t3_duty15", dut.r_duty_q, exp_duty(15));
    count_led(ones);
    chk("t3_led_ones15", ones, exp_duty(15));
    for (int i = 14; i >= 0; i--) begin
      repeat (19) step();
      pulse();
      chk("t3_fall_level", level, i);
    end
    chk("t3_hold_lo", state, 4);
    repeat (19) step();
    pulse();
    chk("t3_hold_lo_1", state, 4);
    repeat (19) step();
    pulse();
    chk("t3_rise_again", state, 1);
    chk("t3_rise_level", level, 0);
    repeat (34) step();
    chk("t3_duty0", dut.r_duty_q, 0);
    count_led(ones);
    chk("t3_led_ones0", ones, 0);

    // 4: enable drop with coincident tick at level 7
    repeat (7) pulse();
    chk("t4_level7", level, 7);
    enable = 1'b0;
    tick   = 1'b1;
    step();
    enable = 1'b1;
    tick   = 1'b0;
    chk("t4_idle", state, 0);
    chk("t4_idle_level", level, 0);
    step();
    chk("t4_rise", state, 1);
    chk("t4_rise_level", level, 0);
    step();
    chk("t4_tick_dropped", level, 0);

    // 5: asynchronous reset mid-FALL at level 9
    repeat (15) pulse();
    repeat (2) pulse();
    repeat (6) pulse();
    chk("t5_level9", level, 9);
    chk("t5_fall", state, 3);
    repeat (20) step();
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (led === 1'b1) begin
        found = 1;
        break;
      end
      step();
    end
    chk("t5_led_high_seen", found, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t5_async_led", led, 0);
    chk("t5_async_level", level, 0);
    chk("t5_async_state", state, 0);
    tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_hold_led", led, 0);
      chk("t5_hold_level", level, 0);
      chk("t5_hold_state", state, 0);
    end
    tick = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("t5_release_rise", state, 1);

    // 6: duty source and boundary-only reload
    repeat (3) pulse();
    chk("t6_level3", level, 3);
    wait_wrap("t6_wrap_a");
    chk("t6_duty3", dut.r_duty_q, exp_duty(3));
    repeat (5) pulse();
    chk("t6_level8", level, 8);
    chk("t6_duty_held", dut.r_duty_q, exp_duty(3));
    wait_wrap("t6_wrap_b");
    chk("t6_duty8", dut.r_duty_q, exp_duty(8));
    repeat (7) pulse();
    chk("t6_level15", level, 15);
    wait_wrap("t6_wrap_c");
    chk("t6_duty15", dut.r_duty_q, exp_duty(15));
    count_led(ones);
    chk("t6_led_ones15", ones, exp_duty(15));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/led_breather.md
# led_breather

Downstream consumer of the board heartbeat divider. Turns its one-cycle `tick` strobe into a "breathing" LED: brightness ramps up, holds, ramps down and holds, in a loop. Brightness drives a free-running PWM comparator. The block sits between the heartbeat/tick generator and the LEDR pins in the board top level.

## Interface
- `PWM_BITS`, default 8: width of the brightness level and the PWM counter; full scale is 2^PWM_BITS-1.
- `HOLD_TICKS`, default 32: number of ticks spent in each hold state; legal range is 1..2^16-1.
- `clk`  input  1: sole clock, CLOCK_50 domain, all logic on the rising edge.
- `reset_n`  input  1: asynchronous, active-low reset. Driven from KEY[0] at the top level.
- `enable`  input  1: run when high; forces idle/dark when low.
- `tick`  input  1: single-cycle step strobe from the upstream heartbeat divider.
- `led`  output  1: registered PWM output. Replicate it onto LEDR at the top level.
- `level`  output  PWM_BITS: current brightness level.
- `state`  output  3: FSM state. IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4.

## Operation
- Reset (asynchronous assert): state=IDLE, level=0, hold counter=0, pwm_cnt=0, duty_q=0, led=0.
- IDLE: level=0.
  - Leave for RISE on the first cycle `enable`=1; no tick is needed.
- RISE: each tick increments level by 1.
  - The tick that makes level equal to full scale enters HOLD_HI and clears the hold counter.
- HOLD_HI: each tick increments the hold counter.
  - The tick that makes it equal to HOLD_TICKS enters FALL and clears the counter.
  - level is unchanged during the hold.
- FALL: each tick decrements level by 1.
  - The tick that makes level 0 enters HOLD_LO and clears the hold counter.
- HOLD_LO: same hold behaviour as HOLD_HI, then enters RISE.
- `enable`=0 in any state, sampled at a clock edge:
  - Next cycle: state=IDLE, level=0, hold counter=0.
  - A tick in the same cycle is ignored; enable has priority over tick.
- Ticks arriving while `enable`=0 are dropped, not queued.
- Arithmetic:
  - level saturates by construction; it never wraps because state changes at the end values.
  - The hold counter is 16 bits.
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter that wraps from full scale to 0.
  - `led` is registered as (pwm_cnt < duty_q).
  - duty_q reloads from the duty source only in the cycle pwm_cnt equals full scale. A level change therefore never truncates or glitches a PWM period.
  - At full scale, `led` is high for 2^N-1 of 2^N cycles. At level 0, `led` is constantly 0.

## Timing
- tick to level/state change: 1 cycle (registered).
- level to duty_q: up to 2^PWM_BITS cycles, applied at the next period boundary.
- duty_q/pwm_cnt to led: 1 cycle.
- Back-to-back ticks, including on consecutive cycles, are each honoured one step per tick.
- Release of reset_n: the first state evaluation is at the first clock edge after release. With `enable` high, the block is in RISE one cycle later.
- Reset asserted mid-ramp: all outputs clear immediately, asynchronously, without waiting for a clock.

## Configuration
- `LED_BREATHER_GAMMA_EN` defined:
  - duty source is (level*level)>>PWM_BITS, a perceptual square-law gamma.
  - The full-width product is computed; the truncated result is PWM_BITS wide.
  - At full scale (level=2^N-1) the duty is 2^N-2.
- Not defined: duty source is level directly.
- Only duty_q is affected. FSM, `level` and `state` are identical in both builds.

## Test plan
All scenarios use PWM_BITS=4, HOLD_TICKS=2.
1. Reset, then `enable`=1 with no ticks:
   - state goes IDLE→RISE one cycle after enable.
   - level=0 and led=0 over 64 cycles.
2. `enable`=1 with 15 ticks:
   - level steps 0→15 one cycle after each tick.
   - state=HOLD_HI after the 15th tick.
   - 2 more ticks give state=FALL with level still 15.
3. Full loop with a tick every 20 cycles:
   - sequence is RISE, HOLD_HI (2 ticks), FALL down to level 0, HOLD_LO (2 ticks), RISE.
   - led duty per 16-cycle period equals duty_q: 15/16 at level 15, 0/16 at level 0.
4. At level 7, pulse `enable`=0 for 1 cycle with a coincident tick:
   - next cycle state=IDLE, level=0.
   - tick ignored.
   - RISE re-entered the cycle after enable returns.
5. Assert reset_n=0 mid-FALL at level 9, off a clock edge:
   - led, level and state are 0 immediately.
   - They stay 0 until release.
6. Build with `LED_BREATHER_GAMMA_EN`:
   - level 8 → duty_q 4; level 15 → duty_q 14; level 3 → duty_q 0.
   - duty_q reloads only at pwm_cnt=15.
